// File: rtl/count_reg.sv
// rtl/count_reg.sv - loadable up-counter with synchronous reset and terminal-count flag
module count_reg #(
  parameter int         D_WIDTH   = 16,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [D_WIDTH-1:0] count_load,
  output logic [D_WIDTH-1:0] count,
  output logic               tc
);

  localparam logic [D_WIDTH-1:0] RST_VAL = RESET_VAL[D_WIDTH-1:0];

  // Power-up value lets simulation start from a defined count before the first reset.
  logic [D_WIDTH-1:0] r_count = RST_VAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= count_load;
    end else if (en) begin
      r_count <= r_count + D_WIDTH'(1);
    end
  end

  assign count = r_count;
  assign tc    = (r_count == {D_WIDTH{1'b1}}) & en;

endmodule

// File: tb/tb_count_reg.sv
// tb/tb_count_reg.sv - table-driven and randomized checks of count_reg at widths 16, 2 and 1
module tb_count_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] count_load = '0;

  logic [15:0] count16;
  logic [1:0]  count2;
  logic        count1;
  logic        tc16, tc2, tc1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain integers advanced by the counting rules.
  int unsigned m16 = 0;
  int unsigned m2  = 2;  // RESET_VAL 6 truncated to 2 bits
  int unsigned m1  = 1;

  always #5 clk = ~clk;

  count_reg #(.D_WIDTH(16), .RESET_VAL(64'd0)) dut16 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .count_load(count_load), .count(count16), .tc(tc16)
  );

  count_reg #(.D_WIDTH(2), .RESET_VAL(64'd6)) dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .count_load(count_load[1:0]), .count(count2), .tc(tc2)
  );

  count_reg #(.D_WIDTH(1), .RESET_VAL(64'd1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .count_load(count_load[0]), .count(count1), .tc(tc1)
  );

  typedef struct {
    logic        r;
    logic        e;
    logic        l;
    logic [15:0] cl;
    logic [15:0] exp_count;
    logic        exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned next_val(input int unsigned cur, input int unsigned modulus,
                                           input int unsigned rv, input logic r, input logic e,
                                           input logic l, input int unsigned cl);
    if (r) return rv % modulus;
    if (l) return cl % modulus;
    if (e) return (cur + 1) % modulus;
    return cur;
  endfunction

  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] cl,
                      output logic tc_pre);
    rst = r; en = e; load = l; count_load = cl;
    #1;
    tc_pre = tc16;
    chk("tc16_model", {63'd0, tc16}, {63'd0, (m16 == 65535) && e});
    chk("tc2_model",  {63'd0, tc2},  {63'd0, (m2 == 3) && e});
    chk("tc1_model",  {63'd0, tc1},  {63'd0, (m1 == 1) && e});
    @(posedge clk);
    #1;
    m16 = next_val(m16, 65536, 0, r, e, l, cl);
    m2  = next_val(m2, 4, 6, r, e, l, cl);
    m1  = next_val(m1, 2, 1, r, e, l, cl);
    chk("count16_model", {48'd0, count16}, 64'(m16));
    chk("count2_model",  {62'd0, count2},  64'(m2));
    chk("count1_model",  {63'd0, count1},  64'(m1));
  endtask

  task automatic add(input logic r, input logic e, input logic l, input logic [15:0] cl,
                     input logic [15:0] ec, input logic et);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.cl = cl; v.exp_count = ec; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  initial begin
    logic t;
    logic [1:0] seq2 [5];

    // Power-up values before any reset edge
    #2;
    chk("init_count16", {48'd0, count16}, 64'd0);
    chk("init_count2",  {62'd0, count2},  64'd2);
    chk("init_count1",  {63'd0, count1},  64'd1);

    add(1, 0, 0, 16'h0000, 16'h0000, 0);
    for (int i = 1; i <= 5; i++) add(0, 1, 0, 16'h0000, 16'(i), 0);
    add(0, 1, 1, 16'h1234, 16'h1234, 0);
    add(0, 1, 0, 16'h0000, 16'h1235, 0);
    add(0, 0, 1, 16'h0007, 16'h0007, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 16'hA5A5, 16'h0007, 0);
    add(1, 1, 1, 16'hBEEF, 16'h0000, 0);
    add(0, 0, 1, 16'hFFFF, 16'hFFFF, 0);
    add(0, 1, 0, 16'h0000, 16'h0000, 1);
    add(0, 1, 0, 16'h0000, 16'h0001, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].cl, t);
      chk($sformatf("vec%0d_tc", i), {63'd0, t}, {63'd0, vecs[i].exp_tc});
      chk($sformatf("vec%0d_count", i), {48'd0, count16}, {48'd0, vecs[i].exp_count});
    end

    // 2-bit wrap sequence with tc tracking count==3
    seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd3; seq2[3] = 2'd0; seq2[4] = 2'd1;
    step(0, 0, 1, 16'h0000, t);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 16'hFFFF, t);
      chk($sformatf("seq2_%0d", i), {62'd0, count2}, {62'd0, seq2[i]});
      en = 1'b1;
      #1;
      chk($sformatf("seq2_tc_%0d", i), {63'd0, tc2}, {63'd0, seq2[i] == 2'd3});
    end

    // 1-bit toggling and mid-count reset to non-zero RESET_VAL
    step(0, 0, 1, 16'h0000, t);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 16'h0000, t);
      chk($sformatf("toggle1_%0d", i), {63'd0, count1}, 64'(((i + 1) % 2)));
    end
    step(1, 1, 0, 16'h0000, t);
    chk("rst_mid2", {62'd0, count2}, 64'd2);
    step(0, 1, 0, 16'h0000, t);
    chk("resume2", {62'd0, count2}, 64'd3);

    for (int i = 0; i < 400; i++) begin
      logic r, e, l;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 4) == 0);
      e = ($urandom_range(0, 9) < 7);
      step(r, e, l, (($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom)), t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
